// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Purpose:
//   Sequences one N x N systolic-array job. It clears the array, streams weight
//   rows (W SRAM) and data columns (D SRAM) into the array with a per-lane skew,
//   then drains the result rows out through a registered write port.
//
//   Job timeline, with cycle 0 being the cycle in which start is sampled:
//     cycle 1               CLEAR  (array_rst_n low)
//     cycles 2 .. 3N+1      FEED   step k = 0 .. 3N-1 (SRAM rows read for k < N)
//     cycles 3N+2 .. 4N+1   DRAIN  step r = 0 .. N-1 (matrix_index = r)
//     cycle 4N+2            FIN    (done pulse, last result write)
//
// Parameters:
//   ARRAY_SIZE  array dimension N, also the number of lanes per SRAM word
//   DATA_WIDTH  bits per lane
//   ADDR_WIDTH  SRAM row address width (at least clog2(ARRAY_SIZE))
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     job request, honoured only when idle
//   busy, done                job in progress, one-cycle completion pulse
//   sram_ren, sram_raddr      shared read port of the W and D SRAMs
//   sram_rdata_w_in/_d_in     SRAM read data, one cycle after sram_ren
//   array_rst_n               array clear, active low
//   alu_start, cycle_num      array shift enable and step index
//   feed_w, feed_d            skewed weight and data lanes
//   matrix_index, mul_outcome array result row select and returned row
//   out_wen/out_waddr/out_wdata  result write port
//   job_cycles                per-job cycle count
//
// Build option:
//   SYSTOLIC_FEEDER_PERF_CNT_EN  when defined, job_cycles counts cycles from
//   CLEAR entry through FIN, holds until the next CLEAR and saturates at
//   16'hFFFF. When undefined, job_cycles is tied to zero.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             sram_ren,
  output logic [ADDR_WIDTH-1:0]            sram_raddr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata_w_in,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata_d_in,
  output logic                             array_rst_n,
  output logic                             alu_start,
  output logic [8:0]                       cycle_num,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feed_w,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] feed_d,
  output logic [4:0]                       matrix_index,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mul_outcome,
  output logic                             out_wen,
  output logic [4:0]                       out_waddr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_wdata,
  output logic [15:0]                      job_cycles
);

  localparam int N        = ARRAY_SIZE;
  localparam int DW       = DATA_WIDTH;
  localparam int LW       = ARRAY_SIZE * DATA_WIDTH;
  localparam int FEED_LEN = 3 * ARRAY_SIZE;
  localparam int CNT_W    = $clog2(FEED_LEN);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] READ_ROWS  = CNT_W'(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_ren_nxt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_sram_ren;
  logic [ADDR_WIDTH-1:0] r_sram_raddr;
  logic                  r_array_rst_n;
  logic                  r_alu_start;
  logic [8:0]            r_cycle_num;
  logic [4:0]            r_matrix_index;
  logic                  r_rvalid;
  logic                  r_out_wen;
  logic [4:0]            r_out_waddr;
  logic [LW-1:0]         r_out_wdata;

  // Next-state and step-counter logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
      S_FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_FEED;
          w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = S_FIN;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
    w_ren_nxt = (w_state_nxt == S_FEED) && (w_cnt_nxt < READ_ROWS);
  end

  // State, counter and control outputs, all registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= {CNT_W{1'b0}};
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sram_ren     <= 1'b0;
      r_sram_raddr   <= {ADDR_WIDTH{1'b0}};
      r_array_rst_n  <= 1'b0;
      r_alu_start    <= 1'b0;
      r_cycle_num    <= 9'd0;
      r_matrix_index <= 5'd0;
      r_rvalid       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_FIN);
      r_sram_ren     <= w_ren_nxt;
      r_sram_raddr   <= w_ren_nxt ? ADDR_WIDTH'(w_cnt_nxt) : {ADDR_WIDTH{1'b0}};
      r_array_rst_n  <= (w_state_nxt != S_CLEAR);
      r_alu_start    <= (w_state_nxt == S_FEED);
      r_cycle_num    <= (w_state_nxt == S_FEED) ? 9'(w_cnt_nxt) : 9'd0;
      r_matrix_index <= (w_state_nxt == S_DRAIN) ? 5'(w_cnt_nxt) : 5'd0;
      // SRAM data is valid the cycle after a read was issued.
      r_rvalid       <= r_sram_ren;
    end
  end

  // Result write port: capture the array row selected in DRAIN step r and
  // write it one cycle later at address r.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_wen   <= 1'b0;
      r_out_waddr <= 5'd0;
      r_out_wdata <= {LW{1'b0}};
    end else if (r_state == S_DRAIN) begin
      r_out_wen   <= 1'b1;
      r_out_waddr <= 5'(r_cnt);
      r_out_wdata <= mul_outcome;
    end else begin
      r_out_wen   <= 1'b0;
      r_out_waddr <= 5'd0;
      r_out_wdata <= {LW{1'b0}};
    end
  end

  // Per-lane skew. Lane j passes through j register stages, so at FEED step k
  // it presents SRAM row k-1-j. Invalid read data is zeroed before entering the
  // delay line, which makes out-of-range rows come out as zero by construction.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [DW-1:0] w_in_w;
    logic [DW-1:0] w_in_d;
    logic [DW-1:0] w_out_w;
    logic [DW-1:0] w_out_d;

    assign w_in_w = r_rvalid ? sram_rdata_w_in[j*DW +: DW] : {DW{1'b0}};
    assign w_in_d = r_rvalid ? sram_rdata_d_in[j*DW +: DW] : {DW{1'b0}};

    if (j == 0) begin : g_direct
      assign w_out_w = w_in_w;
      assign w_out_d = w_in_d;
    end else begin : g_delay
      logic [DW-1:0] r_pipe_w [j];
      logic [DW-1:0] r_pipe_d [j];

      // j-deep shift register for this lane's weight and data values.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < j; s++) begin
            r_pipe_w[s] <= {DW{1'b0}};
            r_pipe_d[s] <= {DW{1'b0}};
          end
        end else begin
          r_pipe_w[0] <= w_in_w;
          r_pipe_d[0] <= w_in_d;
          for (int s = 1; s < j; s++) begin
            r_pipe_w[s] <= r_pipe_w[s-1];
            r_pipe_d[s] <= r_pipe_d[s-1];
          end
        end
      end

      assign w_out_w = r_pipe_w[j-1];
      assign w_out_d = r_pipe_d[j-1];
    end

    // Lanes are forced to zero whenever the array is not shifting.
    assign feed_w[j*DW +: DW] = r_alu_start ? w_out_w : {DW{1'b0}};
    assign feed_d[j*DW +: DW] = r_alu_start ? w_out_d : {DW{1'b0}};
  end

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [15:0] r_job_cycles;

  // Job cycle counter: restarts at 1 on CLEAR entry, counts through FIN,
  // then holds; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_cycles <= 16'd0;
    end else if (w_state_nxt == S_CLEAR) begin
      r_job_cycles <= 16'd1;
    end else if ((w_state_nxt != S_IDLE) && (r_job_cycles != 16'hFFFF)) begin
      r_job_cycles <= r_job_cycles + 16'd1;
    end else begin
      r_job_cycles <= r_job_cycles;
    end
  end

  assign job_cycles = r_job_cycles;
`else
  assign job_cycles = 16'd0;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign sram_ren     = r_sram_ren;
  assign sram_raddr   = r_sram_raddr;
  assign array_rst_n  = r_array_rst_n;
  assign alu_start    = r_alu_start;
  assign cycle_num    = r_cycle_num;
  assign matrix_index = r_matrix_index;
  assign out_wen      = r_out_wen;
  assign out_waddr    = r_out_waddr;
  assign out_wdata    = r_out_wdata;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Self-checking bench for systolic_feeder (N=16, 64-bit lanes). Provides W/D
// SRAM models with one-cycle read latency and a behavioural output-stationary
// array that accumulates the skewed feed lanes. A table of jobs is run in
// order; each job checks control outputs cycle by cycle against the job
// timeline, and result writes are compared against a reference matrix product
// pushed to a scoreboard queue when the job is launched.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N  = 16;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int LW = N * DW;
  localparam int FIN_T = 4 * N + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          sram_ren;
  logic [AW-1:0] sram_raddr;
  logic [LW-1:0] sram_rdata_w_in;
  logic [LW-1:0] sram_rdata_d_in;
  logic          array_rst_n;
  logic          alu_start;
  logic [8:0]    cycle_num;
  logic [LW-1:0] feed_w;
  logic [LW-1:0] feed_d;
  logic [4:0]    matrix_index;
  logic [LW-1:0] mul_outcome;
  logic          out_wen;
  logic [4:0]    out_waddr;
  logic [LW-1:0] out_wdata;
  logic [15:0]   job_cycles;

  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr),
    .sram_rdata_w_in(sram_rdata_w_in), .sram_rdata_d_in(sram_rdata_d_in),
    .array_rst_n(array_rst_n), .alu_start(alu_start), .cycle_num(cycle_num),
    .feed_w(feed_w), .feed_d(feed_d), .matrix_index(matrix_index),
    .mul_outcome(mul_outcome), .out_wen(out_wen), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .job_cycles(job_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;         // 0 identity/index, 1 all ones, 2 random
    int extra_t;     // cycle of an extra start pulse (-1 none)
    int rst_t;       // cycle at which rst is raised (-1 none)
    int exp_writes;  // result writes expected from this job
    int exp_done_t;  // cycle of the done pulse
  } job_t;

  typedef struct {
    logic [4:0]    addr;
    logic [LW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem_w [N][N];   // mem_w[row][lane]
  logic [DW-1:0] mem_d [N][N];
  logic [DW-1:0] hw [3*N][N];
  logic [DW-1:0] hd [3*N][N];
  logic [DW-1:0] carr [N][N];
  int            hcnt;
  wr_t           sbq[$];
  int            checks = 0;
  int            failures = 0;
  int            writes = 0;
  int            cyc = 0;

  task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  // SRAM models: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (sram_ren) begin
        sram_rdata_w_in[j*DW +: DW] <= mem_w[sram_raddr][j];
        sram_rdata_d_in[j*DW +: DW] <= mem_d[sram_raddr][j];
      end else begin
        sram_rdata_w_in[j*DW +: DW] <= 64'hA5A5_5A5A_DEAD_BEEF;
        sram_rdata_d_in[j*DW +: DW] <= 64'h5A5A_A5A5_BEEF_DEAD;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural array: PE(i,j) multiplies weight lane j delayed i steps with
  // data lane i delayed j steps and accumulates.
  initial begin
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (array_rst_n === 1'b0) begin
        hcnt = 0;
      end else if (alu_start === 1'b1 && hcnt < 3*N) begin
        for (int j = 0; j < N; j++) begin
          hw[hcnt][j] = feed_w[j*DW +: DW];
          hd[hcnt][j] = feed_d[j*DW +: DW];
        end
        hcnt++;
        if (hcnt == 3*N) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              logic [DW-1:0] acc;
              acc = 64'd0;
              for (int k = 0; k < 4*N; k++) begin
                if (k-i >= 0 && k-i < 3*N && k-j >= 0 && k-j < 3*N)
                  acc = acc + hw[k-i][j] * hd[k-j][i];
              end
              carr[i][j] = acc;
            end
          end
        end
      end
    end
  end

  always_comb begin
    int mi;
    mi = int'(matrix_index);
    mul_outcome = {LW{1'b0}};
    if (mi < N) begin
      for (int j = 0; j < N; j++) mul_outcome[j*DW +: DW] = carr[mi][j];
    end
  end

  // Scoreboard consumer: every out_wen must match the next expected row.
  initial forever begin
    @(negedge clk);
    if (out_wen === 1'b1) begin
      writes++;
      if (sbq.size() == 0) begin
        chk("spurious_out_wen", cyc, {63'd0, out_wen}, 64'd0);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        chk("out_waddr", cyc, {59'd0, out_waddr}, {59'd0, e.addr});
        for (int j = 0; j < N; j++)
          chk($sformatf("out_wdata[%0d]", j), cyc, out_wdata[j*DW +: DW], e.data[j*DW +: DW]);
      end
    end
  end

  task automatic load_pat(input int pat);
    for (int m = 0; m < N; m++) begin
      for (int j = 0; j < N; j++) begin
        case (pat)
          0: begin
            mem_w[m][j] = (m == j) ? 64'd1 : 64'd0;
            mem_d[m][j] = 64'(16 * j + m);
          end
          1: begin
            mem_w[m][j] = 64'd1;
            mem_d[m][j] = 64'd1;
          end
          default: begin
            mem_w[m][j] = {$urandom, $urandom};
            mem_d[m][j] = {$urandom, $urandom};
          end
        endcase
      end
    end
  endtask

  // Reference product: result row i, lane j = sum_m W[m][j] * D[m][i].
  task automatic push_ref();
    for (int i = 0; i < N; i++) begin
      wr_t e;
      e.addr = 5'(i);
      e.data = {LW{1'b0}};
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] acc;
        acc = 64'd0;
        for (int m = 0; m < N; m++) acc = acc + mem_w[m][j] * mem_d[m][i];
        e.data[j*DW +: DW] = acc;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input int t);
    chk("rst_busy", t, {63'd0, busy}, 64'd0);
    chk("rst_done", t, {63'd0, done}, 64'd0);
    chk("rst_sram_ren", t, {63'd0, sram_ren}, 64'd0);
    chk("rst_sram_raddr", t, {60'd0, sram_raddr}, 64'd0);
    chk("rst_array_rst_n", t, {63'd0, array_rst_n}, 64'd0);
    chk("rst_alu_start", t, {63'd0, alu_start}, 64'd0);
    chk("rst_cycle_num", t, {55'd0, cycle_num}, 64'd0);
    chk("rst_feed_w_any", t, {63'd0, |feed_w}, 64'd0);
    chk("rst_feed_d_any", t, {63'd0, |feed_d}, 64'd0);
    chk("rst_matrix_index", t, {59'd0, matrix_index}, 64'd0);
    chk("rst_out_wen", t, {63'd0, out_wen}, 64'd0);
    chk("rst_out_waddr", t, {59'd0, out_waddr}, 64'd0);
    chk("rst_out_wdata_any", t, {63'd0, |out_wdata}, 64'd0);
    chk("rst_job_cycles", t, {48'd0, job_cycles}, 64'd0);
  endtask

  task automatic run_job(input job_t jb);
    bit infeed;
    bit aborted;
    int k;
    int m;
    logic [DW-1:0] expw;
    logic [DW-1:0] expd;
    load_pat(jb.pat);
    push_ref();
    writes = 0;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= FIN_T; t++) begin
      @(negedge clk);
      infeed = (t >= 2) && (t <= 3*N+1);
      k = t - 2;
      chk("busy", t, {63'd0, busy}, 64'd1);
      chk("array_rst_n", t, {63'd0, array_rst_n}, (t != 1) ? 64'd1 : 64'd0);
      chk("alu_start", t, {63'd0, alu_start}, infeed ? 64'd1 : 64'd0);
      chk("cycle_num", t, {55'd0, cycle_num}, infeed ? 64'(k) : 64'd0);
      chk("sram_ren", t, {63'd0, sram_ren}, (t >= 2 && t <= N+1) ? 64'd1 : 64'd0);
      chk("sram_raddr", t, {60'd0, sram_raddr}, (t >= 2 && t <= N+1) ? 64'(t-2) : 64'd0);
      chk("matrix_index", t, {59'd0, matrix_index},
          (t >= 3*N+2 && t <= 4*N+1) ? 64'(t-(3*N+2)) : 64'd0);
      chk("done", t, {63'd0, done}, (t == jb.exp_done_t) ? 64'd1 : 64'd0);
      chk("out_wen", t, {63'd0, out_wen}, (t >= 3*N+3) ? 64'd1 : 64'd0);
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
      chk("job_cycles", t, {48'd0, job_cycles}, 64'(t));
`else
      chk("job_cycles", t, {48'd0, job_cycles}, 64'd0);
`endif
      for (int j = 0; j < N; j++) begin
        m = k - 1 - j;
        expw = (infeed && m >= 0 && m < N) ? mem_w[m][j] : 64'd0;
        expd = (infeed && m >= 0 && m < N) ? mem_d[m][j] : 64'd0;
        chk($sformatf("feed_w[%0d]", j), t, feed_w[j*DW +: DW], expw);
        chk($sformatf("feed_d[%0d]", j), t, feed_d[j*DW +: DW], expd);
      end
      start = (t == jb.extra_t);
      if (t == jb.rst_t) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs(t + 1);
        rst = 1'b0;
        sbq.delete();
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      chk("idle_busy", FIN_T + 1, {63'd0, busy}, 64'd0);
      chk("idle_done", FIN_T + 1, {63'd0, done}, 64'd0);
      chk("idle_out_wen", FIN_T + 1, {63'd0, out_wen}, 64'd0);
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
      chk("job_cycles_hold", FIN_T + 1, {48'd0, job_cycles}, 64'(FIN_T));
`else
      chk("job_cycles_hold", FIN_T + 1, {48'd0, job_cycles}, 64'd0);
`endif
      chk("pending_writes", FIN_T + 1, 64'(sbq.size()), 64'd0);
    end
    chk("write_count", cyc, 64'(writes), 64'(jb.exp_writes));
  endtask

  job_t jobs [6];

  initial begin
    jobs[0] = '{0, -1, -1, N, FIN_T};  // identity W, indexed D
    jobs[1] = '{1, -1, -1, N, FIN_T};  // all ones
    jobs[2] = '{1, 30, -1, N, FIN_T};  // all ones again, stray start mid-job
    jobs[3] = '{0, -1, 12, 0, FIN_T};  // reset at FEED step 10
    jobs[4] = '{0, -1, -1, N, FIN_T};  // clean job after reset
    jobs[5] = '{2, -1, -1, N, FIN_T};  // random full-width lanes

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(cyc);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) run_job(jobs[n]);
    repeat (4) @(negedge clk);
    chk("final_busy", cyc, {63'd0, busy}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
